// File: rtl/stream_depatch.sv
// stream_depatch: turns one BLOCK x BLOCK pixel block per block-aligned raster
// position back into a full-resolution raster stream. Row 0 of each block is
// held in a small register; rows 1..BLOCK-1 are parked in a line memory until
// the raster reaches them. The pixel and its counters leave two enabled cycles
// after the counters arrive.
module stream_depatch #(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int IMAGE_WIDTH  = 8,
    parameter int FRAME_HEIGHT = 10,
    parameter int FRAME_WIDTH  = 12,
    parameter int LEVEL        = 1
) (
    input  logic                                      clock,
    input  logic                                      n_rst,
    input  logic                                      enable,
    input  logic [(1<<(2*LEVEL))*BIT_WIDTH-1:0]       in_block,
    input  logic [8:0]                                in_vcnt,
    input  logic [9:0]                                in_hcnt,
    output logic [BIT_WIDTH-1:0]                      out_pixel,
    output logic [8:0]                                out_vcnt,
    output logic [9:0]                                out_hcnt
);

    localparam int BLOCK = 1 << LEVEL;
    localparam int NPIX  = BLOCK * BLOCK;
    localparam int ROW_W = BLOCK * BIT_WIDTH;
    localparam int MEM_N = (BLOCK - 1) * BLOCK;
    localparam int MEM_W = MEM_N * BIT_WIDTH;
    localparam int DEPTH = IMAGE_WIDTH / BLOCK;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [8:0] IH = 9'(IMAGE_HEIGHT);
    localparam logic [9:0] IW = 10'(IMAGE_WIDTH);

    // Reject geometries that cannot be tiled by whole blocks.
    if (LEVEL < 1 || LEVEL > 3 ||
        (IMAGE_WIDTH % BLOCK) != 0 || (IMAGE_HEIGHT % BLOCK) != 0 ||
        FRAME_WIDTH < IMAGE_WIDTH || FRAME_HEIGHT < IMAGE_HEIGHT) begin : g_bad_params
        $error("stream_depatch: unsupported geometry");
    end

    logic [LEVEL-1:0]     row_s, col_s;
    logic                 active, capture, rd_en;
    logic [AW-1:0]        addr;

    logic [ROW_W-1:0]     hold_d, hold_q;
    logic [BIT_WIDTH-1:0] row0_pix_d, row0_pix_q;
    logic [8:0]           vcnt1_d, vcnt1_q;
    logic [9:0]           hcnt1_d, hcnt1_q;
    logic [LEVEL-1:0]     row1_d, row1_q, col1_d, col1_q;

    logic [BIT_WIDTH-1:0] out_pixel_d, out_pixel_q;
    logic [8:0]           out_vcnt_d, out_vcnt_q;
    logic [9:0]           out_hcnt_d, out_hcnt_q;

    logic [MEM_W-1:0]     mem [DEPTH];
    logic [MEM_W-1:0]     rd_data_q;

    // Input stage: block position decode, capture, row-0 pixel pick and stage-1 next values.
    always_comb begin
        int sel;
        row_s   = in_vcnt[LEVEL-1:0];
        col_s   = in_hcnt[LEVEL-1:0];
        addr    = in_hcnt[LEVEL +: AW];
        active  = (in_vcnt < IH) && (in_hcnt < IW);
        capture = enable && active && (row_s == '0) && (col_s == '0);
        rd_en   = enable && active && (row_s != '0);

        sel        = BLOCK - 1 - int'(col_s);
        hold_d     = capture ? in_block[NPIX*BIT_WIDTH-1 -: ROW_W] : hold_q;
        row0_pix_d = capture ? in_block[NPIX*BIT_WIDTH-1 -: BIT_WIDTH]
                             : hold_q[sel*BIT_WIDTH +: BIT_WIDTH];

        vcnt1_d = vcnt1_q;
        hcnt1_d = hcnt1_q;
        row1_d  = row1_q;
        col1_d  = col1_q;
        if (enable) begin
            vcnt1_d = in_vcnt;
            hcnt1_d = in_hcnt;
            row1_d  = row_s;
            col1_d  = col_s;
        end else begin
            row0_pix_d = row0_pix_q;
        end
    end

    // Line memory for rows 1..BLOCK-1: written on capture, read one cycle ahead of use.
    always_ff @(posedge clock) begin
        if (capture) mem[addr] <= in_block[MEM_W-1:0];
        if (rd_en)   rd_data_q <= mem[addr];
    end

    // Output stage: choose held row-0 pixel or line-memory pixel, blank outside the image.
    always_comb begin
        int idx;
        logic [BIT_WIDTH-1:0] pix_sel;
        idx = 0;
        if (row1_q != '0) idx = MEM_N - 1 - ((int'(row1_q) - 1) * BLOCK + int'(col1_q));
        pix_sel = (row1_q == '0) ? row0_pix_q : rd_data_q[idx*BIT_WIDTH +: BIT_WIDTH];

        out_pixel_d = out_pixel_q;
        out_vcnt_d  = out_vcnt_q;
        out_hcnt_d  = out_hcnt_q;
        if (enable) begin
            out_vcnt_d  = vcnt1_q;
            out_hcnt_d  = hcnt1_q;
            out_pixel_d = ((vcnt1_q < IH) && (hcnt1_q < IW)) ? pix_sel : '0;
        end
    end

    // Pipeline, hold and output registers, cleared asynchronously.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            hold_q      <= '0;
            row0_pix_q  <= '0;
            vcnt1_q     <= '0;
            hcnt1_q     <= '0;
            row1_q      <= '0;
            col1_q      <= '0;
            out_pixel_q <= '0;
            out_vcnt_q  <= '0;
            out_hcnt_q  <= '0;
        end else begin
            hold_q      <= hold_d;
            row0_pix_q  <= row0_pix_d;
            vcnt1_q     <= vcnt1_d;
            hcnt1_q     <= hcnt1_d;
            row1_q      <= row1_d;
            col1_q      <= col1_d;
            out_pixel_q <= out_pixel_d;
            out_vcnt_q  <= out_vcnt_d;
            out_hcnt_q  <= out_hcnt_d;
        end
    end

    assign out_pixel = out_pixel_q;
    assign out_vcnt  = out_vcnt_q;
    assign out_hcnt  = out_hcnt_q;

endmodule
